// File: rtl/input_port_pkg.sv
// Shared constants for the board input port: register map, debounce default, status bit layout.
package input_port_pkg;
    localparam logic [1:0] ADDR_SW   = 2'd0;
    localparam logic [1:0] ADDR_EVT  = 2'd1;
    localparam logic [1:0] ADDR_BTN  = 2'd2;
    localparam logic [1:0] ADDR_STAT = 2'd3;

    localparam int DEB_CYCLES_DEF = 50000;
    localparam int DATA_W         = 8;
    localparam int IRQ_BIT        = 7;

    typedef struct packed {
        logic              vld;
        logic [DATA_W-1:0] data;
    } rd_rsp_t;
endpackage

// File: rtl/input_port_ctrl_if.sv
// CPU-side read port of the input peripheral: strobe/address in, registered data/valid and irq out.
interface input_port_ctrl_if;
    import input_port_pkg::*;

    logic              rd_en;
    logic [1:0]        addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              irq;

    modport master (output rd_en, addr, input rd_data, rd_valid, irq);
    modport slave  (input rd_en, addr, output rd_data, rd_valid, irq);
endinterface

// File: rtl/input_port_ctrl_debounce_bit.sv
// One input bit: two-flop synchroniser followed by a stability counter; rise pulses on the
// same edge that the debounced value goes 0->1.
module debounce_bit
    import input_port_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic stable,
    output logic rise
);
    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic             done;

    // sync[1] is the synchronised sample; it must differ for DEB_CYCLES edges in a row
    assign done = (sync[1] != stable) && (cnt == CNT_W'(DEB_CYCLES - 1));
    assign rise = done && sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= '0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (done) begin
                stable <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/input_port_ctrl.sv
// Board input peripheral: debounced switches/buttons, sticky press and overrun flags,
// one-cycle-latency read port and level interrupt.
module input_port_ctrl
    import input_port_pkg::*;
#(
    parameter int SW_W       = 8,
    parameter int BTN_W      = 4,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW_W-1:0]   sw,
    input  logic [BTN_W-1:0]  btn,
    input_port_ctrl_if.slave  bus
);
    localparam int NB = SW_W + BTN_W;

    logic [NB-1:0]    raw, stab, rise;
    logic [SW_W-1:0]  sw_stable;
    logic [BTN_W-1:0] btn_stable, btn_rise;
    logic [BTN_W-1:0] evt, ovr, evt_nxt, ovr_nxt;
    logic             clr_evt, clr_ovr, irq_q;
    logic [DATA_W-1:0] rd_mux;
    rd_rsp_t          rsp;
    logic             unused_sw_rise;

    assign raw = {btn, sw};

    generate
        for (genvar i = 0; i < NB; i++) begin : g_deb
            debounce_bit #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb (
                .clk   (clk),
                .rst   (rst),
                .din   (raw[i]),
                .stable(stab[i]),
                .rise  (rise[i])
            );
        end
    endgenerate

    assign sw_stable      = stab[SW_W-1:0];
    assign btn_stable     = stab[NB-1:SW_W];
    assign btn_rise       = rise[NB-1:SW_W];
    assign unused_sw_rise = |rise[SW_W-1:0];

    assign clr_evt = bus.rd_en && (bus.addr == ADDR_EVT);
    assign clr_ovr = bus.rd_en && (bus.addr == ADDR_STAT);

    // a new press wins over a clear landing on the same edge
    assign evt_nxt = (evt & ~{BTN_W{clr_evt}}) | btn_rise;
    assign ovr_nxt = (ovr & ~{BTN_W{clr_ovr}}) | (btn_rise & evt);

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            ADDR_SW:  rd_mux[SW_W-1:0]  = sw_stable;
            ADDR_EVT: rd_mux[BTN_W-1:0] = evt;
            ADDR_BTN: rd_mux[BTN_W-1:0] = btn_stable;
            default: begin
                rd_mux[BTN_W-1:0] = ovr;
                rd_mux[IRQ_BIT]   = |evt;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt   <= '0;
            ovr   <= '0;
            irq_q <= 1'b0;
            rsp   <= '0;
        end else begin
            evt      <= evt_nxt;
            ovr      <= ovr_nxt;
            irq_q    <= |evt_nxt;
            rsp.vld  <= bus.rd_en;
            rsp.data <= bus.rd_en ? rd_mux : '0;
        end
    end

    assign bus.rd_data  = rsp.data;
    assign bus.rd_valid = rsp.vld;
    assign bus.irq      = irq_q;
endmodule

// File: tb/tb_input_port_ctrl.sv
// Directed + random bench for input_port_ctrl against a cycle-level behavioural model.
module tb_input_port_ctrl;
    import input_port_pkg::*;

    localparam int SW_W  = 8;
    localparam int BTN_W = 4;
    localparam int DEB   = 4;
    localparam int CNT_W = 3;
    localparam int NB    = SW_W + BTN_W;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [SW_W-1:0]  sw  = '0;
    logic [BTN_W-1:0] btn = '0;

    input_port_ctrl_if bus ();

    input_port_ctrl #(.SW_W(SW_W), .BTN_W(BTN_W), .DEB_CYCLES(DEB), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .sw (sw),
        .btn(btn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: pin pipeline, per-bit run length of disagreement, flags, expected read response
    bit [NB-1:0]    m_p1, m_s, m_stab;
    int             m_run [NB];
    bit [BTN_W-1:0] m_evt, m_ovr;
    bit             m_vld, m_irq;
    bit [7:0]       m_data;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit [7:0] model_reg(input logic [1:0] a);
        case (a)
            2'd0:    return m_stab[7:0];
            2'd1:    return {4'b0, m_evt};
            2'd2:    return {4'b0, m_stab[NB-1:SW_W]};
            default: return {|m_evt, 3'b0, m_ovr};
        endcase
    endfunction

    task automatic model_reset();
        m_p1 = '0; m_s = '0; m_stab = '0;
        for (int b = 0; b < NB; b++) m_run[b] = 0;
        m_evt = '0; m_ovr = '0; m_vld = 0; m_irq = 0; m_data = '0;
    endtask

    task automatic check_outs();
        chk("rd_valid", {7'b0, bus.rd_valid}, {7'b0, m_vld});
        chk("rd_data", bus.rd_data, m_data);
        chk("irq", {7'b0, bus.irq}, {7'b0, m_irq});
    endtask

    // one clock: model advances from pre-edge inputs, DUT compared at the next falling edge
    task automatic tick();
        bit [BTN_W-1:0] press;
        bit [BTN_W-1:0] old_evt;
        bit [NB-1:0]    pins;
        if (rst) begin
            model_reset();
        end else begin
            pins  = {btn, sw};
            press = '0;
            m_vld  = bus.rd_en;
            m_data = bus.rd_en ? model_reg(bus.addr) : 8'h00;
            for (int b = 0; b < NB; b++) begin
                if (m_s[b] != m_stab[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DEB) begin
                        m_stab[b] = m_s[b];
                        m_run[b]  = 0;
                        if (b >= SW_W && m_s[b]) press[b-SW_W] = 1'b1;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            old_evt = m_evt;
            if (bus.rd_en && bus.addr == 2'd1) m_evt = '0;
            if (bus.rd_en && bus.addr == 2'd3) m_ovr = '0;
            m_evt = m_evt | press;
            m_ovr = m_ovr | (press & old_evt);
            m_irq = |m_evt;
            m_s   = m_p1;
            m_p1  = pins;
        end
        @(posedge clk);
        @(negedge clk);
        check_outs();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic rd(input logic [1:0] a);
        bus.rd_en = 1'b1;
        bus.addr  = a;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic press_btn(input logic [BTN_W-1:0] m);
        btn = m;   ticks(6);
        btn = '0;  ticks(6);
    endtask

    initial begin
        logic [7:0] swv;
        bus.rd_en = 1'b0;
        bus.addr  = 2'd0;
        model_reset();

        // async reset between edges with all pins high
        sw = 8'hFF; btn = 4'hF;
        #12 rst = 1'b1;
        #1;
        chk("rst_rd_valid", {7'b0, bus.rd_valid}, 8'h00);
        chk("rst_rd_data", bus.rd_data, 8'h00);
        chk("rst_irq", {7'b0, bus.irq}, 8'h00);
        tick();
        rst = 1'b0;
        bus.rd_en = 1'b1; bus.addr = 2'd0;
        ticks(6);
        chk("sw_edge6_old", bus.rd_data, 8'h00);
        tick();
        chk("sw_after_reset", bus.rd_data, 8'hFF);
        bus.rd_en = 1'b0;
        rd(2'd1);
        chk("rst_presses", bus.rd_data, 8'h0F);
        btn = '0; ticks(8);

        // glitch rejection, then a pulse just long enough
        btn = 4'h1; ticks(3); btn = '0; ticks(8);
        chk("glitch_irq", {7'b0, bus.irq}, 8'h00);
        rd(2'd2);
        chk("glitch_btn", bus.rd_data, 8'h00);
        rd(2'd1);
        chk("glitch_evt", bus.rd_data, 8'h00);
        btn = 4'h1; ticks(5); btn = '0; ticks(6);
        chk("pulse_irq", {7'b0, bus.irq}, 8'h01);
        rd(2'd1);
        chk("pulse_evt", bus.rd_data, 8'h01);

        // clear-on-read
        press_btn(4'h4);
        rd(2'd1);
        chk("cor_data", bus.rd_data, 8'h04);
        chk("cor_valid", {7'b0, bus.rd_valid}, 8'h01);
        chk("cor_irq", {7'b0, bus.irq}, 8'h00);
        tick();
        chk("cor_valid_drop", {7'b0, bus.rd_valid}, 8'h00);
        rd(2'd1);
        chk("cor_second", bus.rd_data, 8'h00);

        // overrun
        press_btn(4'h2);
        press_btn(4'h2);
        rd(2'd3); chk("ovr_first", bus.rd_data, 8'h82);
        rd(2'd3); chk("ovr_second", bus.rd_data, 8'h80);
        rd(2'd1); chk("ovr_evt", bus.rd_data, 8'h02);
        rd(2'd3); chk("ovr_clear", bus.rd_data, 8'h00);

        // collision: btn[3] stable rise lands on the edge of an addr 1 read
        press_btn(4'h1);
        btn = 4'h8; ticks(5);
        rd(2'd1);
        chk("coll_data", bus.rd_data, 8'h01);
        chk("coll_irq", {7'b0, bus.irq}, 8'h01);
        rd(2'd1);
        chk("coll_evt_after", bus.rd_data, 8'h08);
        btn = '0; ticks(6);
        rd(2'd3);

        // back-to-back reads
        swv = 8'($urandom);
        sw = swv; btn = 4'h5; ticks(7);
        bus.rd_en = 1'b1;
        bus.addr = 2'd0; tick(); chk("b2b_sw", bus.rd_data, swv);
        bus.addr = 2'd2; tick(); chk("b2b_btn", bus.rd_data, 8'h05);
        bus.addr = 2'd3; tick(); chk("b2b_stat", bus.rd_data, 8'h80);
        chk("b2b_valid", {7'b0, bus.rd_valid}, 8'h01);
        bus.rd_en = 1'b0;
        tick();

        // reset while a read response is on the bus
        bus.rd_en = 1'b1; bus.addr = 2'd2;
        tick();
        bus.rd_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrd_valid", {7'b0, bus.rd_valid}, 8'h00);
        chk("midrd_data", bus.rd_data, 8'h00);
        chk("midrd_irq", {7'b0, bus.irq}, 8'h00);
        tick();
        rst = 1'b0;

        // random pins and reads
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) btn[$urandom_range(0, BTN_W-1)] ^= 1'b1;
            if ($urandom_range(0, 7) == 0) sw[$urandom_range(0, SW_W-1)] ^= 1'b1;
            bus.rd_en = ($urandom_range(0, 2) == 0);
            bus.addr  = 2'($urandom_range(0, 3));
            tick();
        end
        bus.rd_en = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/input_port_ctrl.md
Name: input_port_ctrl

Overview:
- Input-direction peripheral of the motherboard, complementing the existing LED and seven-segment output path.
- Synchronises and debounces board slide switches and push buttons.
- Captures button press events in sticky, clear-on-read flags.
- Presents everything to the microprogrammed CPU as a small read-only register port with one-cycle read latency and an interrupt-request line.

Parameters:
- SW_W, 8, number of slide-switch inputs.
- BTN_W, 4, number of push-button inputs.
- DEB_CYCLES, 50000, number of clock cycles an input must stay stably different before the debounced value changes; must be ≥2.
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- clk  in  1  system clock, the single clock domain.
- rst  in  1  asynchronous, active-high reset.
- sw  in  SW_W  raw slide-switch pins, asynchronous.
- btn  in  BTN_W  raw push-button pins, asynchronous, active-high.
- rd_en  in  1  CPU read strobe, one cycle per read.
- addr  in  2  register select.
- rd_data  out  8  read data, valid while rd_valid=1.
- rd_valid  out  1  read-data-valid pulse.
- irq  out  1  high while any press-event flag is set.

Behaviour:
- Reset: one clock (clk); rst is asynchronous and active-high. While rst=1, all of the following are 0 and remain 0 until the first clk edge after rst falls:
  - synchroniser flops, debounce counters, debounced values;
  - event and overrun flags;
  - rd_data, rd_valid, irq.
- Reset mid-read cancels the pending rd_valid.
- Synchroniser: two flops per input bit. The raw pin value appears on the synchronised signal `s` after 2 clk edges.
- Debounce, per bit, with counter `cnt` and debounced value `stable`:
  - If s==stable: cnt<=0.
  - Else if cnt==DEB_CYCLES-1: stable<=s and cnt<=0.
  - Else: cnt<=cnt+1.
  - A clean pin step therefore reaches stable after DEB_CYCLES+2 edges.
  - Any glitch shorter than DEB_CYCLES cycles (measured at s) resets the counter and never changes stable.
- Press event: a 0->1 transition of a debounced button sets evt[i] in the same cycle stable[i] rises.
  - Releases (1->0) generate no event.
  - If evt[i] is already 1 when a new press arrives, ovr[i]<=1 and evt[i] stays 1.
- Register map (8-bit reads; unused bits read 0):
  - addr 0: debounced switch levels sw_stable[SW_W-1:0].
  - addr 1: evt[BTN_W-1:0]; clear-on-read.
  - addr 2: debounced button levels btn_stable.
  - addr 3: ovr[BTN_W-1:0] in bits [3:0]; bit 7 = |evt. Clear-on-read clears the ovr bits only.
- Read timing: rd_en=1 with addr sampled at edge N gives rd_valid=1 and rd_data=register value as sampled at edge N, both registered, during the cycle after N.
  - rd_valid is 0 otherwise; rd_data returns to 0 when rd_valid=0.
  - Back-to-back rd_en on consecutive cycles is legal and gives consecutive rd_valid pulses.
- Clear-on-read collision: if a press event for bit i is detected on the same edge that a read of addr 1 clears the flags:
  - the returned data shows the old evt[i];
  - evt[i] ends set, because the set wins.
  - The same rule applies to ovr against a read of addr 3.
- irq is a registered OR of evt. It falls the cycle after a clearing read, unless a new event arrives.
- Counter width: cnt never exceeds DEB_CYCLES-1, so no wrap-around occurs.

Decomposition:
- Shared package input_port_pkg holds:
  - address constants ADDR_SW=0, ADDR_EVT=1, ADDR_BTN=2, ADDR_STAT=3;
  - the default DEB_CYCLES value;
  - the STAT bit positions (IRQ_BIT=7).
- Sub-module debounce_bit (synchroniser + counter + stable output, parameterised by DEB_CYCLES/CNT_W), instantiated SW_W+BTN_W times via generate.
- Event, overrun, register mux and read pipeline live in the top module.

Test Plan (all scenarios use DEB_CYCLES=4):
- Reset: assert rst asynchronously between edges with sw=8'hFF and btn=4'hF held -> all outputs read 0 immediately; after release, sw_stable=8'hFF at the 6th edge, with reads of addr 0 returning 8'hFF one cycle after rd_en.
- Glitch rejection: btn[0] high for 3 cycles, then low -> btn_stable stays 0, evt=0, irq stays 0; a 5-cycle pulse -> evt[0]=1 and irq=1.
- Clear-on-read: press btn[2], then read addr 1 -> rd_data=8'h04 with rd_valid for exactly 1 cycle; a second read of addr 1 -> 8'h00; irq drops the cycle after the first read.
- Overrun: press btn[1] twice without reading -> addr 3 reads 8'h82; re-reading addr 3 -> 8'h80; after reading addr 1, addr 3 reads 8'h00.
- Collision: time btn[3]'s stable rise onto the same edge as an addr 1 read while evt=4'h1 -> rd_data=8'h01, evt afterwards = 4'h8, irq stays 1.
- Back-to-back reads: rd_en on 3 consecutive cycles with addr 0, 2, 3 -> three consecutive rd_valid pulses carrying the correct values in order.
